// File: rtl/sw_array_feeder_pkg.sv
// Shared types and constants for the Smith-Waterman array feeder.
package sw_array_feeder_pkg;

  // Two-bit nucleotide code: A=00 C=01 G=10 T=11.
  typedef logic [1:0] base_t;

  // Base driven into the chain while the pipeline drains.
  localparam base_t BASE_A = 2'b00;

  localparam int DEF_NUM_PE      = 6;
  localparam int DEF_SCORE_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  // Counter width able to hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_array_feeder_if.sv
// Handshake and PE-facing bundle between the feeder and its neighbours.
interface sw_array_feeder_if #(
  parameter int SCORE_WIDTH = sw_array_feeder_pkg::DEF_SCORE_WIDTH
);
  import sw_array_feeder_pkg::*;

  base_t                  read_base;
  logic                   read_valid;
  logic                   read_last;
  logic                   read_ready;
  base_t                  ref_base;
  logic                   ref_valid;
  logic                   ref_last;
  logic                   ref_ready;
  logic                   sink_stall;
  logic                   pe_stall;
  base_t                  pe_S;
  logic                   pe_store_S;
  base_t                  pe_T;
  logic                   pe_init;
  logic [SCORE_WIDTH-1:0] pe_V;
  logic [SCORE_WIDTH-1:0] pe_F;
  logic                   busy;
  logic                   done;
  logic                   len_err;

  // Source side: read/reference producers and the downstream sink.
  modport master (
    output read_base, read_valid, read_last,
    output ref_base, ref_valid, ref_last, sink_stall,
    input  read_ready, ref_ready, pe_stall, pe_S, pe_store_S, pe_T,
    input  pe_init, pe_V, pe_F, busy, done, len_err
  );

  // Feeder side.
  modport slave (
    input  read_base, read_valid, read_last,
    input  ref_base, ref_valid, ref_last, sink_stall,
    output read_ready, ref_ready, pe_stall, pe_S, pe_store_S, pe_T,
    output pe_init, pe_V, pe_F, busy, done, len_err
  );

endinterface

// File: rtl/sw_array_feeder_read_buffer.sv
// Short-read register file: one 2-bit base per PE, written by index while
// loading and read back by index while shifting into the chain.
module sw_read_buffer
  import sw_array_feeder_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  base_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output base_t            rd_data
);

  base_t mem_r [NUM_PE];

  // Capture the accepted read base; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/sw_array_feeder.sv
// Upstream feeder for the Smith-Waterman PE chain: buffers one short read,
// shifts it in last base first, streams reference bases with init, then
// drains the pipeline and pulses done. Reference bubbles and sink
// back-pressure both stall the array.
module sw_array_feeder
  import sw_array_feeder_pkg::*;
#(
  parameter int NUM_PE      = DEF_NUM_PE,
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int F_INIT      = 0
) (
  input logic              clk,
  input logic              rst,
  sw_array_feeder_if.slave bus
);

  localparam int CNT_W = cnt_width(NUM_PE);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PE - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  base_t            pe_s_r, pe_s_s;
  base_t            pe_t_r, pe_t_s;
  logic             store_r, store_s;
  logic             init_r, init_s;
  logic             bubble_r, bubble_s;
  logic             done_r, done_s;
  logic             len_err_r, len_err_s;
  logic             buf_we_s;
  logic [IDX_W-1:0] buf_widx_s, buf_ridx_s;
  base_t            buf_rdata_s;
  logic             read_ready_s, ref_ready_s;

  sw_read_buffer #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_read_buffer (
    .clk     (clk),
    .wr_en   (buf_we_s),
    .wr_idx  (buf_widx_s),
    .wr_data (bus.read_base),
    .rd_idx  (buf_ridx_s),
    .rd_data (buf_rdata_s)
  );

  // Next state, counter and PE register values; a sink stall freezes everything.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pe_s_s       = pe_s_r;
    pe_t_s       = pe_t_r;
    store_s      = store_r;
    init_s       = init_r;
    bubble_s     = bubble_r;
    done_s       = 1'b0;
    len_err_s    = 1'b0;
    buf_we_s     = 1'b0;
    buf_widx_s   = IDX_W'(cnt_r);
    buf_ridx_s   = IDX_W'(LAST_CNT - cnt_r);
    read_ready_s = 1'b0;
    ref_ready_s  = 1'b0;
    if (bus.sink_stall) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          read_ready_s = 1'b1;
          buf_widx_s   = '0;
          if (bus.read_valid) begin
            buf_we_s = 1'b1;
            cnt_s    = '0;
            if (bus.read_last && (NUM_PE > 1)) begin
              len_err_s = 1'b1;
            end else if (bus.read_last) begin
              state_s = ST_SHIFT;
            end else begin
              cnt_s   = CNT_W'(1);
              state_s = ST_LOAD;
            end
          end else begin
            cnt_s = '0;
          end
        end
        ST_LOAD: begin
          read_ready_s = 1'b1;
          if (bus.read_valid) begin
            buf_we_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
              cnt_s = '0;
              if (bus.read_last) begin
                state_s = ST_SHIFT;
              end else begin
                len_err_s = 1'b1;
                state_s   = ST_IDLE;
              end
            end else if (bus.read_last) begin
              cnt_s     = '0;
              len_err_s = 1'b1;
              state_s   = ST_IDLE;
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_SHIFT: begin
          // Last read base enters first so buf[0] ends up in PE[0].
          store_s = 1'b1;
          pe_s_s  = buf_rdata_s;
          if (cnt_r == LAST_CNT) begin
            cnt_s   = '0;
            state_s = ST_STREAM;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_STREAM: begin
          ref_ready_s = 1'b1;
          store_s     = 1'b0;
          if (bus.ref_valid) begin
            pe_t_s   = bus.ref_base;
            init_s   = 1'b1;
            bubble_s = 1'b0;
            if (bus.ref_last) begin
              cnt_s   = '0;
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_STREAM;
            end
          end else begin
            bubble_s = 1'b1;
          end
        end
        ST_DRAIN: begin
          pe_t_s   = BASE_A;
          init_s   = 1'b0;
          bubble_s = 1'b0;
          if (cnt_r == LAST_CNT) begin
            cnt_s   = '0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and PE-facing output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      pe_s_r    <= BASE_A;
      pe_t_r    <= BASE_A;
      store_r   <= 1'b0;
      init_r    <= 1'b0;
      bubble_r  <= 1'b0;
      done_r    <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pe_s_r    <= pe_s_s;
      pe_t_r    <= pe_t_s;
      store_r   <= store_s;
      init_r    <= init_s;
      bubble_r  <= bubble_s;
      done_r    <= done_s;
      len_err_r <= len_err_s;
    end
  end

  assign bus.read_ready = read_ready_s;
  assign bus.ref_ready  = ref_ready_s;
  assign bus.pe_stall   = bus.sink_stall | bubble_r;
  assign bus.pe_S       = pe_s_r;
  assign bus.pe_store_S = store_r;
  assign bus.pe_T       = pe_t_r;
  assign bus.pe_init    = init_r;
  assign bus.pe_V       = '0;
  assign bus.pe_F       = SCORE_WIDTH'(F_INIT);
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.done       = done_r;
  assign bus.len_err    = len_err_r;

endmodule

// File: tb/tb_sw_array_feeder.sv
// Self-checking bench for sw_array_feeder: a transaction-level scoreboard of
// the beats PE[0] must see on non-stalled cycles, plus directed literal checks.
module tb_sw_array_feeder;
  import sw_array_feeder_pkg::*;

  localparam int NUM_PE = 6;
  localparam int SW     = 10;
  localparam int F_INIT = 0;

  typedef struct packed {
    logic       store;
    logic [1:0] s;
    logic       init;
    logic [1:0] t;
    logic       done;
    logic       busy;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sw_array_feeder_if #(.SCORE_WIDTH(SW)) bus ();

  sw_array_feeder #(
    .NUM_PE      (NUM_PE),
    .SCORE_WIDTH (SW),
    .F_INIT      (F_INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] rd_a [NUM_PE];
  logic [1:0] rf_a [8];
  logic [1:0] shift_gold [NUM_PE];
  logic [1:0] t_gold [8];

  beat_t exp_q [$];
  beat_t exp_b, act_b;
  bit    started = 1'b0;

  logic [1:0] shift_log [16];
  logic [1:0] t_log [16];
  int         shift_n, t_n, stall_cnt, done_n, lerr_n;
  logic [1:0] stall_t_or;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected PE beats for one job: read shifted last-base-first, reference
  // bases with init, then NUM_PE idle beats with done on the last.
  task automatic push_job(input int nref);
    beat_t b;
    for (int k = 0; k < NUM_PE; k++) begin
      b = '0; b.store = 1'b1; b.s = rd_a[NUM_PE-1-k]; b.busy = 1'b1;
      exp_q.push_back(b);
    end
    for (int i = 0; i < nref; i++) begin
      b = '0; b.init = 1'b1; b.t = rf_a[i]; b.busy = 1'b1;
      exp_q.push_back(b);
    end
    for (int d = 0; d < NUM_PE; d++) begin
      b = '0; b.busy = (d != NUM_PE - 1); b.done = (d == NUM_PE - 1);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: each non-stalled cycle consumes the next expected beat or must look idle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      started = 1'b0;
    end else if (!bus.pe_stall) begin
      if (exp_q.size() > 0 && (started || bus.pe_store_S)) begin
        exp_b       = exp_q.pop_front();
        act_b.store = bus.pe_store_S;
        act_b.s     = exp_b.store ? bus.pe_S : 2'b00;
        act_b.init  = bus.pe_init;
        act_b.t     = bus.pe_T;
        act_b.done  = bus.done;
        act_b.busy  = bus.busy;
        chk("beat", 32'(act_b), 32'(exp_b));
        started = (exp_q.size() > 0);
      end else begin
        chk("idle_outputs", {29'd0, bus.pe_store_S, bus.pe_init, bus.done}, 32'd0);
      end
    end
  end

  // Per-job observation logs used by the literal checks.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.pe_stall) begin
        stall_cnt++;
        stall_t_or = stall_t_or | bus.pe_T;
      end
      if (bus.pe_store_S && !bus.pe_stall) begin
        if (shift_n < 16) shift_log[shift_n] = bus.pe_S;
        shift_n++;
      end
      if (bus.pe_init && !bus.pe_stall) begin
        if (t_n < 16) t_log[t_n] = bus.pe_T;
        t_n++;
      end
      if (bus.done) done_n++;
      if (bus.len_err) lerr_n++;
    end
  end

  task automatic clear_logs();
    shift_n = 0; t_n = 0; stall_cnt = 0; done_n = 0; lerr_n = 0; stall_t_or = 2'b00;
  endtask

  task automatic wait_acc(input bit is_ref, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = is_ref ? (bus.ref_ready && bus.ref_valid) : (bus.read_ready && bus.read_valid);
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(is_ref ? "ref_accept_timeout" : "read_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_read(input int n, input int last_idx);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.read_base  = rd_a[i];
      bus.read_valid = 1'b1;
      bus.read_last  = (i == last_idx);
      wait_acc(1'b0, ok);
    end
    bus.read_valid = 1'b0;
    bus.read_last  = 1'b0;
  endtask

  task automatic send_ref(input int n, input bit use_last, input int gap_after, input int gap_len);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.ref_base  = rf_a[i];
      bus.ref_valid = 1'b1;
      bus.ref_last  = use_last && (i == n - 1);
      wait_acc(1'b1, ok);
      if (i == gap_after) begin
        bus.ref_valid = 1'b0;
        bus.ref_last  = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    bus.ref_valid = 1'b0;
    bus.ref_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("done_pulses", done_n, 32'd1);
  endtask

  task automatic check_shift_gold();
    chk("shift_beats", shift_n, NUM_PE);
    for (int k = 0; k < NUM_PE; k++) chk("shift_order", {30'd0, shift_log[k]}, {30'd0, shift_gold[k]});
  endtask

  task automatic check_t_gold();
    chk("ref_beats", t_n, 32'd8);
    for (int k = 0; k < 8; k++) chk("ref_order", {30'd0, t_log[k]}, {30'd0, t_gold[k]});
  endtask

  // Nominal job: 6-base read, 8-base reference back-to-back.
  task automatic nominal_job();
    clear_logs();
    push_job(8);
    send_read(NUM_PE, NUM_PE - 1);
    @(negedge clk);
    chk("shift_latency_before", {31'd0, bus.pe_store_S}, 32'd0);
    @(negedge clk);
    chk("shift_latency_first", {29'd0, bus.pe_store_S, bus.pe_S}, 32'b100);
    send_ref(8, 1'b1, -1, 0);
    wait_done();
    check_shift_gold();
    check_t_gold();
    chk("nominal_no_stall", stall_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rd_a       = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00};
    rf_a       = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    shift_gold = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00};
    t_gold     = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    bus.read_base = 2'b00; bus.read_valid = 1'b0; bus.read_last = 1'b0;
    bus.ref_base  = 2'b00; bus.ref_valid  = 1'b0; bus.ref_last  = 1'b0;
    bus.sink_stall = 1'b0;
    clear_logs();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pe_regs", {bus.pe_S, bus.pe_store_S, bus.pe_T, bus.pe_init}, 32'd0);
    chk("reset_flags", {bus.done, bus.len_err, bus.busy, bus.pe_stall, bus.ref_ready}, 32'd0);
    chk("pe_V_const", 32'(bus.pe_V), 32'd0);
    chk("pe_F_const", 32'(bus.pe_F), F_INIT);
    @(posedge clk); #1;
    rst = 1'b1;

    // Tests 1 and 2.
    nominal_job();

    // Test 3: two-cycle reference bubble after the third base.
    clear_logs();
    push_job(8);
    send_read(NUM_PE, NUM_PE - 1);
    send_ref(8, 1'b1, 2, 2);
    wait_done();
    chk("bubble_stall_cycles", stall_cnt, 32'd2);
    chk("bubble_held_T", {30'd0, stall_t_or}, 32'd0);
    check_t_gold();

    // Test 4: sink stall for three cycles in the middle of the shift.
    clear_logs();
    push_job(8);
    send_read(NUM_PE, NUM_PE - 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sink_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("sink_stall_out", {31'd0, bus.pe_stall}, 32'd1);
      chk("sink_stall_held_S", {29'd0, bus.pe_store_S, bus.pe_S}, 32'b111);
      chk("sink_stall_ready", {30'd0, bus.read_ready, bus.ref_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.sink_stall = 1'b0;
    send_ref(8, 1'b1, -1, 0);
    wait_done();
    check_shift_gold();
    chk("sink_stall_cycles", stall_cnt, 32'd3);

    // Test 5: read_last on the fourth base.
    clear_logs();
    send_read(4, 3);
    @(negedge clk);
    chk("len_err_pulse", {30'd0, bus.len_err, bus.busy}, 32'b10);
    @(negedge clk);
    chk("len_err_clear", {31'd0, bus.len_err}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("len_err_count", lerr_n, 32'd1);
    chk("len_err_no_shift", shift_n, 32'd0);

    // Test 6: reset while streaming, then a clean job.
    clear_logs();
    push_job(8);
    send_read(NUM_PE, NUM_PE - 1);
    send_ref(3, 1'b0, -1, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_pe", {bus.pe_S, bus.pe_store_S, bus.pe_T, bus.pe_init}, 32'd0);
    chk("midrun_reset_flags", {bus.done, bus.len_err, bus.busy, bus.pe_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_read_ready", {31'd0, bus.read_ready}, 32'd1);
    @(posedge clk); #1;
    nominal_job();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
